pulse_burst_arbiter: RTL

//   Shares one programmable pulse generator among N_REQ requesters. Each requester asks for a

---
 rtl/pulse_burst_pkg.sv | 31 +++
 rtl/pulse_burst_arbiter_period_counter.sv | 34 +++
 rtl/pulse_burst_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pulse_burst_pkg.sv
// Shared types and helpers for pulse_burst_arbiter: FSM state enum, minimum period, round-robin pick.
package pulse_burst_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MIN_PERIOD = 2;

  // First set bit of valid at or after ptr, wrapping within n requesters (n <= 16).
  function automatic int rr_pick(input logic [15:0] valid, input int ptr, input int n);
    int   pick;
    int   idx;
    logic found;
    pick  = 0;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i < n && !found) begin
        idx = (ptr + i) % n;
        if (((valid >> idx) & 16'd1) != 16'd0) begin
          pick  = idx;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/pulse_burst_arbiter_period_counter.sv
// Phase counter for the shared pulse generator: counts 0..period-1 while enabled and
// strobes on the last phase.
module pulse_period_counter #(
  parameter int PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear,
  input  logic [PERIOD_W-1:0] period,
  output logic                strobe
);

  logic [PERIOD_W-1:0] phase_q, phase_d;
  logic                last;

  assign last   = (phase_q == period - PERIOD_W'(1));
  assign strobe = enable & last;

  always_comb begin
    phase_d = phase_q;
    if (clear) begin
      phase_d = '0;
    end else if (enable) begin
      phase_d = last ? '0 : phase_q + PERIOD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) phase_q <= '0;
    else       phase_q <= phase_d;
  end

endmodule

// File: rtl/pulse_burst_arbiter.sv
// Round-robin arbiter sharing one pulse generator among N_REQ burst requesters.
// Optional PULSE_BURST_ABORT_EN adds an abort input that ends a running burst early.
//
// state | meaning
// IDLE  | waiting; grants first valid requester at/after RR pointer and latches its burst
// RUN   | phase counter running, one pulse per period until remaining count is spent
// DONE  | one-cycle completion report (done_valid, done_id)
module pulse_burst_arbiter #(
  parameter int N_REQ    = 4,
  parameter int PERIOD_W = 8,
  parameter int COUNT_W  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*PERIOD_W-1:0]   req_period,
  input  logic [N_REQ*COUNT_W-1:0]    req_count,
`ifdef PULSE_BURST_ABORT_EN
  input  logic                        abort,
`endif
  output logic [N_REQ-1:0]            req_ready,
  output logic                        pulse_out,
  output logic [$clog2(N_REQ)-1:0]    pulse_owner,
  output logic                        busy,
  output logic                        done_valid,
  output logic [$clog2(N_REQ)-1:0]    done_id
);
  import pulse_burst_pkg::*;

  localparam int OW = $clog2(N_REQ);

  state_t              state_q, state_d;
  logic [OW-1:0]       ptr_q, ptr_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [COUNT_W-1:0]  remaining_q, remaining_d;
  logic [N_REQ-1:0]    ready;
  logic [PERIOD_W-1:0] sel_period;
  logic [COUNT_W-1:0]  sel_count;
  logic [OW-1:0]       grant_idx;
  logic                strobe;
  logic                abort_w;
  int                  grant;

`ifdef PULSE_BURST_ABORT_EN
  assign abort_w = abort & (state_q == RUN);
`else
  assign abort_w = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    period_d    = period_q;
    remaining_d = remaining_q;
    ready       = '0;
    grant       = rr_pick(16'(req_valid), int'(ptr_q), N_REQ);
    grant_idx   = OW'(grant);
    sel_period  = req_period[grant*PERIOD_W +: PERIOD_W];
    sel_count   = req_count[grant*COUNT_W +: COUNT_W];
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          ready       = N_REQ'(1) << grant;
          owner_d     = grant_idx;
          ptr_d       = (grant_idx == OW'(N_REQ - 1)) ? '0 : grant_idx + OW'(1);
          // Periods below two would make the strobe fire back-to-back or never settle.
          period_d    = (sel_period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : sel_period;
          remaining_d = sel_count;
          state_d     = (sel_count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort_w) begin
          state_d = DONE;
        end else if (strobe) begin
          remaining_d = remaining_q - COUNT_W'(1);
          if (remaining_q == COUNT_W'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      period_q    <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      period_q    <= period_d;
      remaining_q <= remaining_d;
    end
  end

  pulse_period_counter #(
    .PERIOD_W(PERIOD_W)
  ) u_period_counter (
    .clk    (clk),
    .reset  (reset),
    .enable (state_q == RUN),
    .clear  (state_q != RUN),
    .period (period_q),
    .strobe (strobe)
  );

  assign req_ready   = ready;
  assign pulse_out   = strobe & ~abort_w;
  assign busy        = (state_q != IDLE);
  assign pulse_owner = busy ? owner_q : '0;
  assign done_valid  = (state_q == DONE);
  assign done_id     = done_valid ? owner_q : '0;

endmodule
